// File: rtl/ai_core_pkg.sv
// ai_core_pkg: shared FSM state enum and default widths for the operand unpacker
package ai_core_pkg;
  typedef enum logic [0:0] {EMPTY = 1'b0, DRAIN = 1'b1} state_t;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_ELEM_WIDTH = 8;
  localparam int DEF_OUT_WIDTH = 16;
endpackage

// File: rtl/sign_extender.sv
// sign_extender: sign- or zero-extends an IN_WIDTH value to OUT_WIDTH
module sign_extender #(
  parameter int IN_WIDTH = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 is_signed,
  output logic [OUT_WIDTH-1:0] out_data
);
  logic signed [IN_WIDTH:0] ext;
  assign ext = {is_signed & in_data[IN_WIDTH-1], in_data};
  assign out_data = OUT_WIDTH'(ext);
endmodule

// File: rtl/operand_unpacker.sv
// operand_unpacker: splits a packed word into extended lanes; OPERAND_UNPACKER_LAST_EN adds in_last/out_last
module operand_unpacker
  import ai_core_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  localparam int LANES = WORD_WIDTH / ELEM_WIDTH,
  localparam int LW = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_signed,
`ifdef OPERAND_UNPACKER_LAST_EN
  input  logic                  in_last,
  output logic                  out_last,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [LW-1:0]         out_lane
);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  if (WORD_WIDTH % ELEM_WIDTH != 0 || OUT_WIDTH < ELEM_WIDTH || LANES < 2) begin : g_bad_cfg
    $error("operand_unpacker: illegal WORD_WIDTH/ELEM_WIDTH/OUT_WIDTH combination");
  end
  state_t state;
  logic [WORD_WIDTH-1:0] word_q;
  logic sgn_q;
  logic [LW-1:0] lane;
  logic [ELEM_WIDTH-1:0] elem;
  logic out_hs, lane_end, accept;
  assign out_valid = state == DRAIN;
  assign out_hs = out_valid && out_ready;
  assign lane_end = lane == LAST;
  // rst_n gate keeps in_ready low while reset is held
  assign in_ready = rst_n && !flush && (state == EMPTY || (out_hs && lane_end));
  assign accept = in_valid && in_ready;
  assign out_lane = lane;
  assign elem = word_q[lane*ELEM_WIDTH +: ELEM_WIDTH];
  sign_extender #(.IN_WIDTH(ELEM_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_ext (
    .in_data  (elem),
    .is_signed(sgn_q),
    .out_data (out_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      word_q <= '0;
      sgn_q <= 1'b0;
      lane <= '0;
    end else if (flush) begin
      state <= EMPTY;
      lane <= '0;
    end else if (accept) begin
      state <= DRAIN;
      word_q <= in_data;
      sgn_q <= in_signed;
      lane <= '0;
    end else if (out_hs) begin
      state <= lane_end ? EMPTY : DRAIN;
      lane <= lane_end ? '0 : lane + 1'b1;
    end
  end
`ifdef OPERAND_UNPACKER_LAST_EN
  logic last_q;
  assign out_last = last_q && lane_end;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) last_q <= 1'b0;
    else if (accept) last_q <= in_last;
  end
`endif
endmodule

// File: tb/tb_operand_unpacker.sv
// tb_operand_unpacker: directed self-checking bench for operand_unpacker (default parameters)
module tb_operand_unpacker;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_signed, out_ready;
  logic in_ready, out_valid;
  logic [31:0] in_data;
  logic [15:0] out_data;
  logic [1:0] out_lane;
`ifdef OPERAND_UNPACKER_LAST_EN
  logic in_last, out_last;
`endif
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] sx [4] = '{16'h0001, 16'h007F, 16'hFFFF, 16'hFF80};
  logic [15:0] ux [4] = '{16'h0001, 16'h007F, 16'h00FF, 16'h0080};
  logic [15:0] bx [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
  always #5 clk = ~clk;
  operand_unpacker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_signed(in_signed),
`ifdef OPERAND_UNPACKER_LAST_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lane (out_lane)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d, input logic s, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_signed = s;
`ifdef OPERAND_UNPACKER_LAST_EN
    in_last = l;
`endif
    #1 check("in_ready_accept", {31'b0, in_ready}, 1);
    tick;
    in_valid = 1'b0;
    in_data = 32'hDEAD_BEEF;
    in_signed = ~s;
  endtask
  task automatic drain(input string tag, input logic [15:0] e0, e1, e2, e3);
    logic [15:0] e [4];
    e = '{e0, e1, e2, e3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check({tag, "_valid"}, {31'b0, out_valid}, 1);
      check({tag, "_lane"}, {30'b0, out_lane}, i);
      check({tag, "_data"}, {16'b0, out_data}, {16'b0, e[i]});
      tick;
    end
    #1 check({tag, "_done"}, {31'b0, out_valid}, 0);
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b0;
    in_data = '0;
`ifdef OPERAND_UNPACKER_LAST_EN
    in_last = 1'b0;
`endif
    tick; tick;
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_lane", {30'b0, out_lane}, 0);
    check("rst_data", {16'b0, out_data}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", {31'b0, in_ready}, 1);
    tick;
    send(32'h80FF7F01, 1'b1, 1'b0);
    drain("signed", sx[0], sx[1], sx[2], sx[3]);
    send(32'h80FF7F01, 1'b0, 1'b0);
    drain("unsigned", ux[0], ux[1], ux[2], ux[3]);
    send(32'h80FF7F01, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick; tick;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", {31'b0, out_valid}, 1);
      check("bp_lane", {30'b0, out_lane}, 2);
      check("bp_data", {16'b0, out_data}, 32'hFFFF);
      check("bp_in_ready", {31'b0, in_ready}, 0);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 check("bp_resume_lane2", {16'b0, out_data}, 32'hFFFF);
    tick;
    #1 check("bp_resume_lane3", {16'b0, out_data}, 32'hFF80);
    check("bp_resume_lane", {30'b0, out_lane}, 3);
    tick;
    #1 check("bp_done", {31'b0, out_valid}, 0);
    in_valid = 1'b1; in_data = 32'h80FF7F01; in_signed = 1'b1;
    tick;
    in_data = 32'h04030201; in_signed = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("b2b_valid", {31'b0, out_valid}, 1);
      check("b2b_lane", {30'b0, out_lane}, k % 4);
      check("b2b_data", {16'b0, out_data}, {16'b0, (k < 4) ? sx[k] : bx[k-4]});
      check("b2b_in_ready", {31'b0, in_ready}, {31'b0, k % 4 == 3});
      tick;
      if (k == 3) in_valid = 1'b0;
    end
    #1 check("b2b_done", {31'b0, out_valid}, 0);
    send(32'h80FF7F01, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick;
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h04030201; in_signed = 1'b0;
    #1 check("flush_in_ready", {31'b0, in_ready}, 0);
    check("flush_lane", {30'b0, out_lane}, 1);
    tick;
    flush = 1'b0;
    #1 check("flush_valid_drop", {31'b0, out_valid}, 0);
`ifdef OPERAND_UNPACKER_LAST_EN
    check("flush_last", {31'b0, out_last}, 0);
`endif
    check("flush_then_ready", {31'b0, in_ready}, 1);
    tick;
    in_valid = 1'b0;
    drain("after_flush", bx[0], bx[1], bx[2], bx[3]);
    send(32'h80FF7F01, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick; tick;
    #1 check("rst_mid_lane", {30'b0, out_lane}, 2);
    rst_n = 1'b0;
    tick;
    check("rst_mid_valid", {31'b0, out_valid}, 0);
    check("rst_mid_lane0", {30'b0, out_lane}, 0);
    check("rst_mid_in_ready", {31'b0, in_ready}, 0);
`ifdef OPERAND_UNPACKER_LAST_EN
    check("rst_mid_last", {31'b0, out_last}, 0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("rst_no_stale", {31'b0, out_valid}, 0);
      tick;
    end
`ifdef OPERAND_UNPACKER_LAST_EN
    send(32'h80FF7F01, 1'b1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("last_flag", {31'b0, out_last}, {31'b0, i == 3});
      tick;
    end
    send(32'h80FF7F01, 1'b1, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("no_last_flag", {31'b0, out_last}, 0);
      tick;
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_unpacker.md
OPERAND_UNPACKER -- requirements
Module: operand_unpacker

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: packed input word width in bits.
REQ-002 SHALL have parameter ELEM_WIDTH, default 8: width of one packed element.
REQ-003 SHALL have parameter OUT_WIDTH, default 16: width of each extended output element.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1: synchronous drop of the held word.
REQ-007 SHALL have port in_valid, input, 1: packed word offered.
REQ-008 SHALL have port in_ready, output, 1: packed word accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_data, input, WORD_WIDTH: packed elements, lane 0 in the LSBs.
REQ-010 SHALL have port in_signed, input, 1: element signedness, sampled with the word.
REQ-011 SHALL have port out_valid, output, 1: element valid.
REQ-012 SHALL have port out_ready, input, 1: element consumed when out_valid and out_ready are both high.
REQ-013 SHALL have port out_data, output, OUT_WIDTH: extended element.
REQ-014 SHALL have port out_lane, output, $clog2(LANES): lane index of out_data.

Function
REQ-015 SHALL define LANES = WORD_WIDTH/ELEM_WIDTH; an elaboration error SHALL occur if WORD_WIDTH % ELEM_WIDTH != 0, OUT_WIDTH < ELEM_WIDTH, or LANES < 2.
REQ-016 SHALL use FSM states EMPTY and DRAIN.
- EMPTY -> DRAIN on input handshake.
- DRAIN -> EMPTY on handshake of lane LANES-1 with no new word accepted.
REQ-017 SHALL drive in_ready = !flush && (state==EMPTY || (out_valid && out_ready && lane==LANES-1)).
- This allows back-to-back words with zero bubble cycles.
REQ-018 SHALL register word and signedness on input handshake and set lane to 0.
- Latency: out_valid is high the cycle after acceptance.
REQ-019 SHALL emit lanes 0..LANES-1 in order, advancing lane only on an output handshake.
- out_data, out_lane, and out_valid SHALL be held stable while out_valid && !out_ready.
REQ-020 SHALL form out_data from the current lane's ELEM_WIDTH slice:
- sign-extended when latched signedness is 1;
- zero-extended otherwise.
REQ-021 SHALL wrap lane from LANES-1 to 0; out_lane SHALL never exceed LANES-1.
REQ-022 SHALL, on flush, go to EMPTY and deassert out_valid next cycle, discarding remaining lanes.
- flush has priority over a simultaneous input handshake, since in_ready is low during flush.
REQ-023 SHALL sustain throughput of one element per cycle when out_ready is held high.
REQ-024 SHALL ignore in_data and in_signed when no handshake occurs.

Reset
REQ-025 SHALL, while rst_n is low at a clock edge, enter EMPTY and reset outputs:
- out_valid=0, out_lane=0, out_data=0;
- in_ready=0 during reset, 1 in the first cycle after release.
REQ-026 SHALL lose any partially drained word on reset mid-operation, with no element emitted afterwards.

Configuration
REQ-027 SHALL support macro OPERAND_UNPACKER_LAST_EN.
- When defined, add ports in_last (input, 1) and out_last (output, 1).
- in_last is latched with the word.
- out_last = latched in_last && lane==LANES-1, and is 0 on reset or flush.
- When undefined, these ports and their register are absent and all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum (EMPTY, DRAIN) and default width constants in the shared ai_core package.
REQ-029 SHALL perform extension by instantiating the existing sign_extender sub-module (IN_WIDTH=ELEM_WIDTH, OUT_WIDTH=OUT_WIDTH) on the selected lane slice; no duplicated extension logic.

Verification
REQ-030 SHALL verify signed extension with defaults: word 0x80FF7F01, signed=1, out_ready=1 -> out_data 0x0001, 0x007F, 0xFFFF, 0xFF80 on 4 consecutive cycles, out_lane 0..3.
REQ-031 SHALL verify unsigned extension: the same word with signed=0 -> 0x0001, 0x007F, 0x00FF, 0x0080.
REQ-032 SHALL verify backpressure: out_ready low for 3 cycles at lane 2 -> 0xFFFF and lane 2 held stable, in_ready low, then resume with 0xFF80.
REQ-033 SHALL verify back-to-back words: two words presented continuously -> 8 elements on 8 consecutive cycles, in_ready high exactly on the lane-3 handshake cycles.
REQ-034 SHALL verify flush: flush asserted at lane 1 with in_valid high -> no handshake that cycle, out_valid=0 next cycle, a new word accepted the following cycle starting at lane 0.
REQ-035 SHALL verify reset mid-operation: rst_n low during lane 2 -> out_valid=0 and out_lane=0 after the edge, with no stale lanes after release; with OPERAND_UNPACKER_LAST_EN defined, out_last=1 only on lane 3 of a word sent with in_last=1.
